rc_cascade_disp: RTL and testbench

//   Downstream stage of the 4-bit counter: consumes its count nibble (Qa..Qd) and ripple carry (Rc).

---
 rtl/rc_cascade_disp_if.sv | 22 ++
 rtl/rc_cascade_disp.sv | 126 ++++++++++++
 tb/tb_rc_cascade_disp.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rc_cascade_disp_if.sv
// rc_cascade_disp_if: counter-to-display bundle.
// Ports: Qa..Qd, Rc from the counter; AN, SEGMENT, ovf to the pins.
interface rc_cascade_disp_if;
  logic       Qa;
  logic       Qb;
  logic       Qc;
  logic       Qd;
  logic       Rc;
  logic [3:0] AN;
  logic [7:0] SEGMENT;
  logic       ovf;

  modport master (
    output Qa, Qb, Qc, Qd, Rc,
    input  AN, SEGMENT, ovf
  );

  modport slave (
    input  Qa, Qb, Qc, Qd, Rc,
    output AN, SEGMENT, ovf
  );
endinterface

// File: rtl/rc_cascade_disp.sv
// rc_cascade_disp: extends a 4-bit counter to 16 bits, scans 4 hex digits.
// Ports: clk, rst (sync, high); bus.slave: Qa..Qd,Rc in; AN,SEGMENT,ovf out.
// Optional macro OVF_BLINK_EN: blinks the display while ovf is set.
module rc_cascade_disp #(
  parameter int SCAN_DIV = 17
) (
  input  logic               clk,
  input  logic               rst,
  rc_cascade_disp_if.slave   bus
);

  localparam logic [SCAN_DIV-1:0] DIV_ONE = 1;

  logic [4:0]          r_s1;
  logic [4:0]          r_s2;
  logic                r_rc_s3;
  logic [11:0]         r_hi_cnt;
  logic                r_ovf;
  logic [SCAN_DIV-1:0] r_div;
  logic                r_run;
  logic [3:0]          r_an;
  logic [7:0]          r_seg;

  logic                w_rc_rise;
  logic [3:0]          w_q;
  logic [15:0]         w_disp;
  logic [1:0]          w_sel;
  logic [3:0]          w_nib;
  logic [3:0]          w_an;
  logic [7:0]          w_seg;
  logic                w_blank;

  // bit 0 carries Rc, bits 4:1 the nibble
  assign w_rc_rise = r_s2[0] & ~r_rc_s3;
  assign w_q       = r_s2[4:1];
  assign w_disp    = {r_hi_cnt, w_q};
  assign w_sel     = r_div[SCAN_DIV-1 -: 2];

  always_comb begin
    w_an  = 4'b1111;
    w_nib = 4'h0;
    unique case (w_sel)
      2'd0: begin w_an = 4'b1110; w_nib = w_disp[3:0];   end
      2'd1: begin w_an = 4'b1101; w_nib = w_disp[7:4];   end
      2'd2: begin w_an = 4'b1011; w_nib = w_disp[11:8];  end
      2'd3: begin w_an = 4'b0111; w_nib = w_disp[15:12]; end
      default: begin w_an = 4'b1111; w_nib = 4'h0;      end
    endcase
  end

  always_comb begin
    w_seg = 8'hFF;
    unique case (w_nib)
      4'h0: w_seg = 8'hC0;
      4'h1: w_seg = 8'hF9;
      4'h2: w_seg = 8'hA4;
      4'h3: w_seg = 8'hB0;
      4'h4: w_seg = 8'h99;
      4'h5: w_seg = 8'h92;
      4'h6: w_seg = 8'h82;
      4'h7: w_seg = 8'hF8;
      4'h8: w_seg = 8'h80;
      4'h9: w_seg = 8'h90;
      4'hA: w_seg = 8'h88;
      4'hB: w_seg = 8'h83;
      4'hC: w_seg = 8'hC6;
      4'hD: w_seg = 8'hA1;
      4'hE: w_seg = 8'h86;
      4'hF: w_seg = 8'h8E;
      default: w_seg = 8'hFF;
    endcase
  end

`ifdef OVF_BLINK_EN
  logic [3:0] r_blink;

  // steps once per scan wrap; upper bit gives an 8-on/8-off cadence
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink <= 4'd0;
    end else if (&r_div) begin
      r_blink <= r_blink + 4'd1;
    end
  end

  assign w_blank = r_ovf & r_blink[3];
`else
  assign w_blank = 1'b0;
`endif

  // r_run holds the pins dark for one cycle after reset release
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 5'd0;
      r_s2     <= 5'd0;
      r_rc_s3  <= 1'b0;
      r_hi_cnt <= 12'd0;
      r_ovf    <= 1'b0;
      r_div    <= '0;
      r_run    <= 1'b0;
      r_an     <= 4'b1111;
      r_seg    <= 8'hFF;
    end else begin
      r_s1    <= {bus.Qd, bus.Qc, bus.Qb, bus.Qa, bus.Rc};
      r_s2    <= r_s1;
      r_rc_s3 <= r_s2[0];
      r_div   <= r_div + DIV_ONE;
      r_run   <= 1'b1;
      if (w_rc_rise) begin
        r_hi_cnt <= r_hi_cnt + 12'd1;
        if (&r_hi_cnt) begin
          r_ovf <= 1'b1;
        end
      end
      if (r_run) begin
        r_an  <= w_blank ? 4'b1111 : w_an;
        r_seg <= w_seg;
      end
    end
  end

  assign bus.AN      = r_an;
  assign bus.SEGMENT = r_seg;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_rc_cascade_disp.sv
// tb_rc_cascade_disp: randomized bench for rc_cascade_disp.
// Model tracks the 16-bit value and the scan position arithmetically.
module tb_rc_cascade_disp;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rc_cascade_disp_if bus ();

  rc_cascade_disp #(.SCAN_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] hex [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  int          t;
  int          n_pass;
  int          n_total;
  logic [11:0] m_hi;
  logic        m_ovf;
  logic [3:0]  m_q;

  task automatic tick();
    @(posedge clk);
    t++;
    #1;
  endtask

  task automatic set_q(input logic [3:0] v);
    bus.Qa = v[0];
    bus.Qb = v[1];
    bus.Qc = v[2];
    bus.Qd = v[3];
    m_q    = v;
  endtask

  // k edges after reset release, the pins show the digit of div=k-1
  function automatic int exp_sel(input int k);
    return ((k - 1) % 16) / 4;
  endfunction

  function automatic logic [3:0] exp_an(input int k);
    logic [3:0] a;
    a = 4'b0001 << exp_sel(k);
    return ~a;
  endfunction

  function automatic logic [7:0] exp_seg(input int k);
    logic [15:0] d;
    d = {m_hi, m_q};
    return hex[d[exp_sel(k)*4 +: 4]];
  endfunction

  task automatic pulse(input int hw, input int lw);
    bus.Rc = 1'b1;
    repeat (hw) tick();
    bus.Rc = 1'b0;
    repeat (lw) tick();
    if (m_hi == 12'hFFF) m_ovf = 1'b1;
    m_hi = m_hi + 12'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Rc = 1'b0;
    set_q(4'h0);
    tick();
    tick();
    n_total++;
    if (bus.AN !== 4'b1111)
      $display("FAIL rst_an got %b want 1111", bus.AN);
    else n_pass++;
    n_total++;
    if (bus.SEGMENT !== 8'hFF)
      $display("FAIL rst_seg got %h want FF", bus.SEGMENT);
    else n_pass++;
    n_total++;
    if (bus.ovf !== 1'b0)
      $display("FAIL rst_ovf got %b want 0", bus.ovf);
    else n_pass++;
    rst = 1'b0;
    t = 0;
    m_hi = 12'd0;
    m_ovf = 1'b0;
    tick();
    n_total++;
    if (bus.AN !== 4'b1111)
      $display("FAIL rel1_an got %b want 1111", bus.AN);
    else n_pass++;
    tick();
    n_total++;
    if (bus.AN !== 4'b1110)
      $display("FAIL rel2_an got %b want 1110", bus.AN);
    else n_pass++;
    n_total++;
    if (bus.SEGMENT !== 8'hC0)
      $display("FAIL rel2_seg got %h want C0", bus.SEGMENT);
    else n_pass++;
  endtask

  task automatic test_scan(input logic [3:0] v);
    set_q(v);
    repeat (4) tick();
    repeat (64) begin
      tick();
      n_total++;
      if (bus.AN !== exp_an(t))
        $display("FAIL scan_an t=%0d got %b want %b",
                 t, bus.AN, exp_an(t));
      else n_pass++;
      n_total++;
      if (bus.SEGMENT !== exp_seg(t))
        $display("FAIL scan_seg t=%0d got %h want %h",
                 t, bus.SEGMENT, exp_seg(t));
      else n_pass++;
    end
  endtask

  task automatic test_rc_hold();
    bus.Rc = 1'b1;
    tick();
    tick();
    n_total++;
    if (dut.r_hi_cnt !== m_hi)
      $display("FAIL hold_early got %h want %h", dut.r_hi_cnt, m_hi);
    else n_pass++;
    tick();
    m_hi = m_hi + 12'd1;
    n_total++;
    if (dut.r_hi_cnt !== m_hi)
      $display("FAIL hold_lat got %h want %h", dut.r_hi_cnt, m_hi);
    else n_pass++;
    repeat (17) tick();
    bus.Rc = 1'b0;
    repeat (6) tick();
    n_total++;
    if (dut.r_hi_cnt !== m_hi)
      $display("FAIL hold_once got %h want %h", dut.r_hi_cnt, m_hi);
    else n_pass++;
    repeat (16) begin
      tick();
      n_total++;
      if (bus.SEGMENT !== exp_seg(t) || bus.AN !== exp_an(t))
        $display("FAIL hold_disp t=%0d got %b/%h want %b/%h",
                 t, bus.AN, bus.SEGMENT, exp_an(t), exp_seg(t));
      else n_pass++;
    end
  endtask

  task automatic test_ovf();
    int cnt;
    int want;
    while (m_hi != 12'hFFF)
      pulse($urandom_range(1, 3), $urandom_range(1, 3));
    repeat (4) tick();
    n_total++;
    if (dut.r_hi_cnt !== 12'hFFF || bus.ovf !== 1'b0)
      $display("FAIL preload got %h/%b want FFF/0",
               dut.r_hi_cnt, bus.ovf);
    else n_pass++;
    repeat (16) begin
      tick();
      n_total++;
      if (bus.SEGMENT !== exp_seg(t) || bus.AN !== exp_an(t))
        $display("FAIL fff_disp t=%0d got %b/%h want %b/%h",
                 t, bus.AN, bus.SEGMENT, exp_an(t), exp_seg(t));
      else n_pass++;
    end
    bus.Rc = 1'b1;
    tick();
    tick();
    n_total++;
    if (dut.r_hi_cnt !== 12'hFFF || bus.ovf !== 1'b0)
      $display("FAIL wrap_pre got %h/%b want FFF/0",
               dut.r_hi_cnt, bus.ovf);
    else n_pass++;
    tick();
    m_hi = 12'd0;
    m_ovf = 1'b1;
    n_total++;
    if (dut.r_hi_cnt !== m_hi || bus.ovf !== m_ovf)
      $display("FAIL wrap got %h/%b want %h/%b",
               dut.r_hi_cnt, bus.ovf, m_hi, m_ovf);
    else n_pass++;
    bus.Rc = 1'b0;
    repeat (100) begin
      tick();
      n_total++;
      if (bus.ovf !== m_ovf)
        $display("FAIL ovf_sticky t=%0d got %b want 1", t, bus.ovf);
      else n_pass++;
    end
    cnt = 0;
    repeat (256) begin
      tick();
      if (bus.AN === 4'b1111) cnt++;
    end
`ifdef OVF_BLINK_EN
    want = 128;
`else
    want = 0;
`endif
    n_total++;
    if (cnt != want)
      $display("FAIL blank_cnt got %0d want %0d", cnt, want);
    else n_pass++;
  endtask

  task automatic test_rst_inflight();
    bus.Rc = 1'b1;
    tick();
    rst = 1'b1;
    bus.Rc = 1'b0;
    tick();
    n_total++;
    if (bus.AN !== 4'b1111 || bus.SEGMENT !== 8'hFF || bus.ovf !== 1'b0)
      $display("FAIL mid_rst got %b/%h/%b want 1111/FF/0",
               bus.AN, bus.SEGMENT, bus.ovf);
    else n_pass++;
    rst = 1'b0;
    t = 0;
    m_hi = 12'd0;
    m_ovf = 1'b0;
    repeat (8) tick();
    n_total++;
    if (dut.r_hi_cnt !== 12'd0 || bus.ovf !== 1'b0)
      $display("FAIL inflight got %h/%b want 000/0",
               dut.r_hi_cnt, bus.ovf);
    else n_pass++;
  endtask

  initial begin
    t = 0;
    n_pass = 0;
    n_total = 0;
    m_hi = 12'd0;
    m_ovf = 1'b0;
    bus.Rc = 1'b0;
    set_q(4'h0);
    test_reset();
    test_scan(4'h5);
    test_scan(4'($urandom_range(0, 15)));
    test_rc_hold();
    test_ovf();
    test_rst_inflight();
    test_scan(4'($urandom_range(0, 15)));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
